vend_ctrl: RTL
==============

# vend_ctrl

Transaction controller for the vending datapath. It accepts coins from the coin acceptor and keeps a running credit. Once credit reaches the item price, it runs a dispense handshake with the product dispenser, then returns any surplus credit as nickels through a change handshake. It also handles cancel, inactivity timeout and dispenser fault refund, and is the single owner of the dispenser and change-return mechanisms.

## Interface
- PRICE, 3: item price in 5-cent units; legal range 1..(2^CREDIT_W − 1).
- CREDIT_W, 5: credit register width (units of 5 cents).
- TIMEOUT, 255: idle cycles in COLLECT before automatic refund; must be ≥ 1.
- ACK_TO, 63: cycles allowed in DISP without disp_ack before fault; must be ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- arstn  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle strobe, coin present.
- coin_val  in  2  coin code: 0 = nickel (1 unit), 1 = dime (2), 2 = quarter (5), 3 = invalid.
- cancel  in  1  user cancel request, level-sampled.
- disp_ack  in  1  dispenser acknowledge (4-phase).
- chg_ack  in  1  change-return acknowledge (4-phase).
- coin_en  out  1  acceptor may present coins.
- coin_rej  out  1  one-cycle pulse: last strobed coin rejected and must be returned by the acceptor.
- disp_req  out  1  dispense request.
- chg_req  out  1  return-one-nickel request.
- vend_done  out  1  one-cycle pulse on completed dispense.
- fault  out  1  one-cycle pulse on dispenser ack timeout.
- credit  out  CREDIT_W  current credit.

## Operation
- States: IDLE, COLLECT, DISP, DISP_REL, CHANGE, CHG_REL. All outputs are registered.
- coin_en = 1 only in IDLE or COLLECT. A coin strobed in any other state gets coin_rej and no credit.
- **Coin acceptance** (IDLE or COLLECT, coin_valid = 1): the coin is rejected (coin_rej, credit unchanged) if:
  - coin_val = 3, or
  - credit + value > 2^CREDIT_W − 1, or
  - cancel = 1 in the same cycle (cancel wins).
  Otherwise credit += value.
- **IDLE:**
  - accepted coin → DISP if the new credit ≥ PRICE, else COLLECT.
  - cancel with credit = 0 → ignored.
- **COLLECT:**
  - accepted coin with new credit ≥ PRICE → DISP.
  - cancel → CHANGE.
  - timer reaches TIMEOUT → CHANGE.
  - Idle timer clears on entry and on every accepted coin; it increments each COLLECT cycle with no accepted coin.
- **DISP:**
  - disp_req = 1.
  - disp_ack = 1 → credit −= PRICE, vend_done pulse, go to DISP_REL.
  - ACK_TO consecutive cycles without ack → fault pulse, go to CHANGE with credit unchanged (full refund).
  - cancel is ignored.
- **DISP_REL:**
  - disp_req = 0.
  - Wait for disp_ack = 0, then go to CHANGE if credit > 0, else IDLE.
- **CHANGE:**
  - chg_req = 1.
  - chg_ack = 1 → credit −= 1, go to CHG_REL.
- **CHG_REL:**
  - chg_req = 0.
  - Wait for chg_ack = 0, then go to CHANGE if credit > 0, else IDLE.
- Entering CHANGE with credit = 0 does not occur: every path into CHANGE has credit ≥ 1.

## Timing
- Reset (arstn low, asynchronous): state = IDLE, credit = 0, counters = 0, coin_en = 1, all other outputs 0. The reset takes effect immediately, even mid-handshake. disp_req and chg_req drop without waiting for ack, and any credit is lost.
- Coin strobed at edge N:
  - credit is updated after edge N.
  - coin_rej is high for the cycle after edge N.
  - If price is reached, disp_req is high from edge N, with coin_en low in the same cycle.
- disp_ack sampled high at edge M: disp_req low and vend_done high after M, credit reduced after M.
- Each change nickel takes at least 2 cycles (req/ack, then release).
- Fault: disp_req stays high for exactly ACK_TO cycles, then drops with a one-cycle fault pulse, and chg_req rises on the following edge.
- A late disp_ack arriving in CHANGE is ignored.
- credit never wraps; PRICE ≤ credit is guaranteed whenever the subtract occurs.

## Test plan
- **Reset:** assert arstn mid-DISP → disp_req = 0, credit = 0, coin_en = 1 immediately; no vend_done afterwards.
- **Exact payment, PRICE = 3:**
  - dime then nickel → disp_req high the cycle after the nickel.
  - ack → credit = 0, vend_done pulse, IDLE after ack release, no chg_req.
- **Overpay:** quarter → dispense, credit = 2, then exactly 2 chg_req/chg_ack handshakes, credit 2 → 1 → 0, IDLE.
- **Cancel and timeout:**
  - dime then cancel → 2 nickels returned, no disp_req.
  - separately, nickel then TIMEOUT idle cycles → 1 nickel returned.
  - coin + cancel in the same cycle → coin_rej, refund of prior credit only.
- **Dispenser fault:** dime + nickel, disp_ack held 0 → fault pulse after ACK_TO cycles, 3 nickels refunded, vend_done never asserted.
- **Rejection:**
  - coin_val = 3 → coin_rej, credit unchanged.
  - with CREDIT_W = 5 and PRICE = 31: credit 30 plus a dime → coin_rej, credit stays 30.
  - coin strobed during CHANGE → coin_rej, credit unchanged.

Source files
------------

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending transaction controller.
//
// Accepts coins into a running credit. Once the credit covers PRICE it runs
// a 4-phase dispense handshake, then returns any surplus one nickel at a time
// through a 4-phase change handshake. Cancel, collect-phase inactivity and a
// dispenser acknowledge timeout all end in a refund of the remaining credit.
//
// Handshakes: disp_req/disp_ack and chg_req/chg_ack are 4-phase. A request
// rises, stays high until the matching ack is sampled high, then drops. The
// controller waits for the ack to return low before it raises the next
// request. An ack is honoured only while its request is high.
//
// Ports:
//   clk         rising-edge clock
//   arstn       asynchronous active-low reset
//   coin_valid  one-cycle coin strobe
//   coin_val    coin code: 0 nickel(1), 1 dime(2), 2 quarter(5), 3 invalid
//   cancel      user cancel, level-sampled
//   disp_ack    dispenser acknowledge
//   chg_ack     change-return acknowledge
//   coin_en     acceptor may present coins
//   coin_rej    one-cycle pulse, last strobed coin rejected
//   disp_req    dispense request
//   chg_req     return-one-nickel request
//   vend_done   one-cycle pulse on completed dispense
//   fault       one-cycle pulse on dispenser ack timeout
//   credit      current credit in 5-cent units
module vend_ctrl #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 5,
    parameter int TIMEOUT  = 255,
    parameter int ACK_TO   = 63
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                chg_ack,
    output logic                coin_en,
    output logic                coin_rej,
    output logic                disp_req,
    output logic                chg_req,
    output logic                vend_done,
    output logic                fault,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COLLECT  = 3'd1;
    localparam logic [2:0] S_DISP     = 3'd2;
    localparam logic [2:0] S_DISP_REL = 3'd3;
    localparam logic [2:0] S_CHANGE   = 3'd4;
    localparam logic [2:0] S_CHG_REL  = 3'd5;

    // One counter serves as the collect idle timer and the dispense ack timer;
    // the two are never live at the same time.
    localparam int CNT_MAX = (TIMEOUT > ACK_TO) ? TIMEOUT : ACK_TO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SUM_W   = CREDIT_W + 1;

    localparam logic [SUM_W-1:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    logic [2:0]          state, nxt_state;
    logic [CNT_W-1:0]    cnt, nxt_cnt;
    logic [CREDIT_W-1:0] nxt_credit;
    logic [2:0]          coin_units;
    logic [SUM_W-1:0]    sum;
    logic                open, accept, reject;
    logic                nxt_vend, nxt_fault, chg_gap;

    always_comb begin
        case (coin_val)
            2'd0:    coin_units = 3'd1;
            2'd1:    coin_units = 3'd2;
            2'd2:    coin_units = 3'd5;
            default: coin_units = 3'd0;
        endcase
    end

    // Sum is one bit wider than credit so overflow is visible, not wrapped.
    assign sum    = {1'b0, credit} + SUM_W'(coin_units);
    assign open   = (state == S_IDLE) || (state == S_COLLECT);
    assign accept = open && coin_valid && (coin_val != 2'd3) && !cancel &&
                    (sum <= CREDIT_MAX);
    assign reject = coin_valid && !accept;

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_credit = credit;
        nxt_vend   = 1'b0;
        nxt_fault  = 1'b0;
        chg_gap    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_credit = sum[CREDIT_W-1:0];
                    nxt_cnt    = '0;
                    nxt_state  = (sum >= SUM_W'(PRICE)) ? S_DISP : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    nxt_credit = sum[CREDIT_W-1:0];
                    nxt_cnt    = '0;
                    if (sum >= SUM_W'(PRICE)) nxt_state = S_DISP;
                end else if (cancel) begin
                    nxt_state = S_CHANGE;
                    nxt_cnt   = '0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    nxt_state = S_CHANGE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            S_DISP: begin
                if (disp_ack) begin
                    nxt_credit = credit - CREDIT_W'(PRICE);
                    nxt_vend   = 1'b1;
                    nxt_state  = S_DISP_REL;
                end else if (cnt == CNT_W'(ACK_TO - 1)) begin
                    // Fault: credit kept for a full refund; chg_req is held
                    // off for one cycle so it rises the edge after fault.
                    nxt_fault = 1'b1;
                    chg_gap   = 1'b1;
                    nxt_state = S_CHANGE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            S_DISP_REL: begin
                if (!disp_ack) nxt_state = (credit != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (chg_req && chg_ack) begin
                    nxt_credit = credit - 1'b1;
                    nxt_state  = S_CHG_REL;
                end
            end
            S_CHG_REL: begin
                if (!chg_ack) nxt_state = (credit != '0) ? S_CHANGE : S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            credit    <= '0;
            coin_en   <= 1'b1;
            coin_rej  <= 1'b0;
            disp_req  <= 1'b0;
            chg_req   <= 1'b0;
            vend_done <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            credit    <= nxt_credit;
            coin_en   <= (nxt_state == S_IDLE) || (nxt_state == S_COLLECT);
            coin_rej  <= reject;
            disp_req  <= (nxt_state == S_DISP);
            chg_req   <= (nxt_state == S_CHANGE) && !chg_gap;
            vend_done <= nxt_vend;
            fault     <= nxt_fault;
        end
    end

endmodule
